fe_fifo_reader: RTL

//  Read-side decoder for the front-end capture FIFO, on the cwusb_clk side. Pops {cmd,time,data} entries

---
 rtl/fe_fifo_reader_pkg.sv | 28 ++
 rtl/fe_fifo_reader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fe_fifo_reader_pkg.sv
// Shared definitions for the front-end capture FIFO reader:
// FIFO command encodings, reader FSM states, saturating counter helper.
package fe_fifo_reader_pkg;

  // Command encodings must match the capture-side writer.
  typedef enum logic [1:0] {
    FE_FIFO_CMD_DATA = 2'd0,
    FE_FIFO_CMD_TIME = 2'd1,
    FE_FIFO_CMD_STAT = 2'd2,
    FE_FIFO_CMD_STRM = 2'd3
  } fe_cmd_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_HOLD = 2'd2
  } rd_state_e;

  localparam int unsigned FE_CMD_W  = 2;
  localparam int unsigned FE_STAT_W = 32;

  function automatic logic [FE_STAT_W-1:0] sat_inc(
    input logic [FE_STAT_W-1:0] v
  );
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fe_fifo_reader.sv
// Front-end capture FIFO reader: pops {cmd,time,data} entries, rebuilds
// absolute times from per-entry deltas, emits events on a valid/ready port.
// Ports: cwusb_clk/reset_n (async low); I_fifo_dout/I_fifo_empty/O_fifo_rd
// FWFT FIFO read side; I_fifo_flush re-arm; O_ev_* event stream with
// I_ev_ready; O_time_wrap sticky wrap; O_idle; O_n_events/O_n_time_pkts
// counters, built only when FE_READER_STATS_EN is defined (else tied 0).
module fe_fifo_reader
  import fe_fifo_reader_pkg::*;
#(
  parameter int pTIMESTAMP_FULL_WIDTH = 16,
  parameter int pDATA_WIDTH           = 8,
  parameter int pABS_TIME_WIDTH       = 32
) (
  input  logic                       cwusb_clk,
  input  logic                       reset_n,
  input  logic [2+pTIMESTAMP_FULL_WIDTH+pDATA_WIDTH-1:0] I_fifo_dout,
  input  logic                       I_fifo_empty,
  output logic                       O_fifo_rd,
  input  logic                       I_fifo_flush,
  output logic                       O_ev_valid,
  input  logic                       I_ev_ready,
  output logic [1:0]                 O_ev_cmd,
  output logic [pABS_TIME_WIDTH-1:0] O_ev_time,
  output logic [pDATA_WIDTH-1:0]     O_ev_data,
  output logic                       O_time_wrap,
  output logic                       O_idle,
  output logic [31:0]                O_n_events,
  output logic [31:0]                O_n_time_pkts
);

  localparam int TW      = pTIMESTAMP_FULL_WIDTH;
  localparam int DW      = pDATA_WIDTH;
  localparam int AW      = pABS_TIME_WIDTH;
  localparam int SUM_W   = AW + 1;
  localparam int DAT_LSB = 0;
  localparam int TIM_LSB = DW;
  localparam int CMD_LSB = DW + TW;

  rd_state_e         state_q, state_d;
  logic              run_q;
  fe_cmd_e           cmd_q, cmd_d;
  logic [TW-1:0]     dt_q, dt_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [AW-1:0]     abs_q, abs_d;
  logic              wrap_q, wrap_d;
  logic              ev_valid_q, ev_valid_d;
  fe_cmd_e           ev_cmd_q, ev_cmd_d;
  logic [AW-1:0]     ev_time_q, ev_time_d;
  logic [DW-1:0]     ev_data_q, ev_data_d;

  logic              head_ok;
  logic              accept;
  logic              pop;
  logic              is_time;
  logic [SUM_W-1:0]  sum;

  always_comb begin
    // run_q keeps the pop strobe low until the first edge after reset.
    head_ok = run_q && !I_fifo_empty && !I_fifo_flush;
    accept  = ev_valid_q && I_ev_ready;
    is_time = (cmd_q == FE_FIFO_CMD_TIME);
    sum     = {1'b0, abs_q} + SUM_W'(dt_q);
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE:  pop = head_ok;
      S_POP:   pop = head_ok && is_time;
      S_HOLD:  pop = head_ok && accept;
      default: pop = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    dt_d       = dt_q;
    dat_d      = dat_q;
    abs_d      = abs_q;
    wrap_d     = wrap_q;
    ev_valid_d = ev_valid_q;
    ev_cmd_d   = ev_cmd_q;
    ev_time_d  = ev_time_q;
    ev_data_d  = ev_data_q;

    if (pop) begin
      cmd_d = fe_cmd_e'(I_fifo_dout[CMD_LSB +: FE_CMD_W]);
      dt_d  = I_fifo_dout[TIM_LSB +: TW];
      dat_d = I_fifo_dout[DAT_LSB +: DW];
    end

    unique case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_POP;
      end
      S_POP: begin
        abs_d = sum[AW-1:0];
        if (sum[AW]) wrap_d = 1'b1;
        if (is_time) begin
          state_d = pop ? S_POP : S_IDLE;
        end else begin
          ev_cmd_d   = cmd_q;
          ev_time_d  = sum[AW-1:0];
          ev_data_d  = dat_q;
          ev_valid_d = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (accept) begin
          ev_valid_d = 1'b0;
          state_d    = pop ? S_POP : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything; the latched entry is dropped.
    if (I_fifo_flush) begin
      state_d    = S_IDLE;
      ev_valid_d = 1'b0;
      abs_d      = '0;
      wrap_d     = 1'b0;
    end
  end

  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      cmd_q      <= FE_FIFO_CMD_DATA;
      dt_q       <= '0;
      dat_q      <= '0;
      abs_q      <= '0;
      wrap_q     <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_cmd_q   <= FE_FIFO_CMD_DATA;
      ev_time_q  <= '0;
      ev_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      cmd_q      <= cmd_d;
      dt_q       <= dt_d;
      dat_q      <= dat_d;
      abs_q      <= abs_d;
      wrap_q     <= wrap_d;
      ev_valid_q <= ev_valid_d;
      ev_cmd_q   <= ev_cmd_d;
      ev_time_q  <= ev_time_d;
      ev_data_q  <= ev_data_d;
    end
  end

`ifdef FE_READER_STATS_EN
  logic [FE_STAT_W-1:0] n_ev_q, n_ev_d;
  logic [FE_STAT_W-1:0] n_tp_q, n_tp_d;

  always_comb begin
    n_ev_d = n_ev_q;
    n_tp_d = n_tp_q;
    if (accept) n_ev_d = sat_inc(n_ev_q);
    if (state_q == S_POP && is_time) n_tp_d = sat_inc(n_tp_q);
    if (I_fifo_flush) begin
      n_ev_d = '0;
      n_tp_d = '0;
    end
  end

  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      n_ev_q <= '0;
      n_tp_q <= '0;
    end else begin
      n_ev_q <= n_ev_d;
      n_tp_q <= n_tp_d;
    end
  end

  assign O_n_events    = n_ev_q;
  assign O_n_time_pkts = n_tp_q;
`else
  assign O_n_events    = '0;
  assign O_n_time_pkts = '0;
`endif

  assign O_fifo_rd   = pop;
  assign O_ev_valid  = ev_valid_q;
  assign O_ev_cmd    = ev_cmd_q;
  assign O_ev_time   = ev_time_q;
  assign O_ev_data   = ev_data_q;
  assign O_time_wrap = wrap_q;
  assign O_idle      = (state_q == S_IDLE) && I_fifo_empty && !ev_valid_q;

endmodule
